dma_cpu_programmer: RTL and testbench

//  CPU-side bus initiator that programs the 8237A-style DMA slave over its 4-bit register port.

---
 rtl/dma_cpu_programmer_pkg.sv | 51 +++++
 rtl/dma_cpu_programmer_bus_cycle.sv | 104 ++++++++++
 rtl/dma_cpu_programmer.sv | 172 +++++++++++++++++
 tb/tb_dma_cpu_programmer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_cpu_programmer_pkg.sv
// Shared types for the 8237A-style DMA register programmer: register address codes,
// sequencer and bus-phase enums, and the single bus operation record.
package dma_cpu_programmer_pkg;

  localparam logic [3:0] REG_STATUS      = 4'd8;
  localparam logic [3:0] REG_SINGLE_MASK = 4'd10;
  localparam logic [3:0] REG_MODE        = 4'd11;
  localparam logic [3:0] REG_CLR_BPFF    = 4'd12;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_CLR_BPFF,
    SEQ_ADDR_LO,
    SEQ_ADDR_HI,
    SEQ_CNT_LO,
    SEQ_CNT_HI,
    SEQ_MODE,
    SEQ_UNMASK,
    SEQ_RB_CLR,
    SEQ_RB_ADDR_LO,
    SEQ_RB_ADDR_HI,
    SEQ_RB_CNT_LO,
    SEQ_RB_CNT_HI,
    SEQ_STAT_RD,
    SEQ_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_GAP
  } bus_phase_t;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } bus_op_t;

  // Per-channel address/count registers sit at 2*ch and 2*ch+1 in the 4-bit space.
  function automatic logic [3:0] addr_reg(input logic [1:0] ch);
    return {1'b0, ch, 1'b0};
  endfunction

  function automatic logic [3:0] count_reg(input logic [1:0] ch);
    return {1'b0, ch, 1'b1};
  endfunction

endpackage

// File: rtl/dma_cpu_programmer_bus_cycle.sv
// Single-access bus engine: SETUP -> STROBE -> HOLD -> GAP, with a start/ack handshake
// that lets the next access begin straight out of the finishing cycle.
module dma_bus_cycle
  import dma_cpu_programmer_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       start,
  input  bus_op_t    op,
  output logic       ack,
  output logic [7:0] rd_data,
  output logic       CS_N,
  output logic       IOR_N,
  output logic       IOW_N,
  output logic [3:0] A,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [7:0] DB_in
);

  localparam bit         HAS_GAP     = (GAP_CYCLES != 0);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

  bus_phase_t phase, phase_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load;
  bus_op_t    op_q;
  logic       active;

  // NOTE: every output of a combinational block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    load      = 1'b0;
    ack       = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) begin
          load      = 1'b1;
          phase_nxt = PH_SETUP;
        end
      end
      PH_SETUP: begin
        phase_nxt = PH_STROBE;
        cnt_nxt   = STROBE_LAST;
      end
      PH_STROBE: begin
        if (cnt == 4'd0) phase_nxt = PH_HOLD;
        else             cnt_nxt   = cnt - 4'd1;
      end
      PH_HOLD: begin
        if (HAS_GAP) begin
          phase_nxt = PH_GAP;
          cnt_nxt   = GAP_LAST;
        end else begin
          ack       = 1'b1;
          load      = start;
          phase_nxt = start ? PH_SETUP : PH_IDLE;
        end
      end
      PH_GAP: begin
        if (cnt == 4'd0) begin
          ack       = 1'b1;
          load      = start;
          phase_nxt = start ? PH_SETUP : PH_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: phase_nxt = PH_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase   <= PH_IDLE;
      cnt     <= 4'd0;
      op_q    <= '0;
      rd_data <= 8'h00;
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      if (load) op_q <= op;
      // Read data is captured on the edge that ends the strobe.
      if (phase == PH_STROBE && cnt == 4'd0 && op_q.rd) rd_data <= DB_in;
    end
  end

  // Pins decode straight from registered phase, so reset releases the bus immediately.
  assign active = (phase == PH_SETUP) || (phase == PH_STROBE) || (phase == PH_HOLD);
  assign CS_N   = !active;
  assign IOR_N  = !((phase == PH_STROBE) && op_q.rd);
  assign IOW_N  = !((phase == PH_STROBE) && !op_q.rd);
  assign A      = op_q.addr;
  assign DB_out = op_q.data;
  assign DB_oe  = active && !op_q.rd;

endmodule

// File: rtl/dma_cpu_programmer.sv
// CPU-side programmer for an 8237A-style DMA: sequences channel-setup writes and status reads.
// Optional readback verification of address/count is enabled by defining DMA_PROG_READBACK_EN.
module dma_cpu_programmer
  import dma_cpu_programmer_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_channel,
  input  logic [15:0] req_base_addr,
  input  logic [15:0] req_word_count,
  input  logic [5:0]  req_mode,
  input  logic        req_unmask,
  input  logic        stat_req,
  output logic        stat_valid,
  output logic [7:0]  stat_data,
  output logic        done,
  output logic        readback_err,
  output logic        CS_N,
  output logic        IOR_N,
  output logic        IOW_N,
  output logic [3:0]  A,
  output logic [7:0]  DB_out,
  output logic        DB_oe,
  input  logic [7:0]  DB_in
);

`ifdef DMA_PROG_READBACK_EN
  localparam seq_state_t AFTER_CFG = SEQ_RB_CLR;
`else
  localparam seq_state_t AFTER_CFG = SEQ_DONE;
`endif

  seq_state_t  state, nxt;
  logic [1:0]  ch_q;
  logic [15:0] addr_q, cnt_q;
  logic [5:0]  mode_q;
  logic        unmask_q;
  logic        start, ack;
  bus_op_t     op;
  logic [7:0]  rd_data;

  always_comb begin
    nxt = state;
    case (state)
      SEQ_IDLE: begin
        // A setup request takes priority; a coincident status request is dropped.
        if (req_valid)     nxt = SEQ_CLR_BPFF;
        else if (stat_req) nxt = SEQ_STAT_RD;
      end
      SEQ_DONE: nxt = SEQ_IDLE;
      default: begin
        if (ack) begin
          case (state)
            SEQ_CLR_BPFF:   nxt = SEQ_ADDR_LO;
            SEQ_ADDR_LO:    nxt = SEQ_ADDR_HI;
            SEQ_ADDR_HI:    nxt = SEQ_CNT_LO;
            SEQ_CNT_LO:     nxt = SEQ_CNT_HI;
            SEQ_CNT_HI:     nxt = SEQ_MODE;
            SEQ_MODE:       nxt = unmask_q ? SEQ_UNMASK : AFTER_CFG;
            SEQ_UNMASK:     nxt = AFTER_CFG;
            SEQ_RB_CLR:     nxt = SEQ_RB_ADDR_LO;
            SEQ_RB_ADDR_LO: nxt = SEQ_RB_ADDR_HI;
            SEQ_RB_ADDR_HI: nxt = SEQ_RB_CNT_LO;
            SEQ_RB_CNT_LO:  nxt = SEQ_RB_CNT_HI;
            SEQ_RB_CNT_HI:  nxt = SEQ_DONE;
            default:        nxt = SEQ_IDLE;
          endcase
        end
      end
    endcase
  end

  // The operation for the upcoming state is offered during the finishing cycle of the
  // current access, so consecutive accesses run back to back.
  always_comb begin
    op = '0;
    case (nxt)
      SEQ_CLR_BPFF, SEQ_RB_CLR: op.addr = REG_CLR_BPFF;
      SEQ_ADDR_LO: begin op.addr = addr_reg(ch_q);  op.data = addr_q[7:0];  end
      SEQ_ADDR_HI: begin op.addr = addr_reg(ch_q);  op.data = addr_q[15:8]; end
      SEQ_CNT_LO:  begin op.addr = count_reg(ch_q); op.data = cnt_q[7:0];   end
      SEQ_CNT_HI:  begin op.addr = count_reg(ch_q); op.data = cnt_q[15:8];  end
      SEQ_MODE:    begin op.addr = REG_MODE;        op.data = {mode_q, ch_q}; end
      SEQ_UNMASK:  begin op.addr = REG_SINGLE_MASK; op.data = {6'b0, ch_q};   end
      SEQ_RB_ADDR_LO, SEQ_RB_ADDR_HI: begin op.rd = 1'b1; op.addr = addr_reg(ch_q);  end
      SEQ_RB_CNT_LO,  SEQ_RB_CNT_HI:  begin op.rd = 1'b1; op.addr = count_reg(ch_q); end
      SEQ_STAT_RD: begin op.rd = 1'b1; op.addr = REG_STATUS; end
      default: ;
    endcase
  end

  assign start = (nxt != state) && (nxt != SEQ_IDLE) && (nxt != SEQ_DONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= SEQ_IDLE;
      ch_q       <= 2'd0;
      addr_q     <= 16'h0000;
      cnt_q      <= 16'h0000;
      mode_q     <= 6'd0;
      unmask_q   <= 1'b0;
      stat_valid <= 1'b0;
      stat_data  <= 8'h00;
    end else begin
      state      <= nxt;
      stat_valid <= (state == SEQ_STAT_RD) && ack;
      if (state == SEQ_IDLE && req_valid) begin
        ch_q     <= req_channel;
        addr_q   <= req_base_addr;
        cnt_q    <= req_word_count;
        mode_q   <= req_mode;
        unmask_q <= req_unmask;
      end
      if (state == SEQ_STAT_RD && ack) stat_data <= rd_data;
    end
  end

  assign req_ready = (state == SEQ_IDLE);
  assign done      = (state == SEQ_DONE);

`ifdef DMA_PROG_READBACK_EN
  logic       err_q;
  logic       rb_check;
  logic [7:0] rb_expect;

  always_comb begin
    rb_check  = 1'b1;
    rb_expect = 8'h00;
    case (state)
      SEQ_RB_ADDR_LO: rb_expect = addr_q[7:0];
      SEQ_RB_ADDR_HI: rb_expect = addr_q[15:8];
      SEQ_RB_CNT_LO:  rb_expect = cnt_q[7:0];
      SEQ_RB_CNT_HI:  rb_expect = cnt_q[15:8];
      default:        rb_check  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                                    err_q <= 1'b0;
    else if (ack && rb_check && rd_data != rb_expect) err_q <= 1'b1;
  end

  assign readback_err = err_q;
`else
  assign readback_err = 1'b0;
`endif

  dma_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_bus (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .start  (start),
    .op     (op),
    .ack    (ack),
    .rd_data(rd_data),
    .CS_N   (CS_N),
    .IOR_N  (IOR_N),
    .IOW_N  (IOW_N),
    .A      (A),
    .DB_out (DB_out),
    .DB_oe  (DB_oe),
    .DB_in  (DB_in)
  );

endmodule

// File: tb/tb_dma_cpu_programmer.sv
// Self-checking bench for dma_cpu_programmer: directed and randomized setup requests,
// status reads, reset abort and a 3/0 strobe/gap instance, against a behavioural DMA model.
module tb_dma_cpu_programmer;

  localparam int S = 1;
  localparam int G = 1;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  logic        req_valid, req_ready, req_unmask, stat_req, stat_valid, done, readback_err;
  logic [1:0]  req_channel;
  logic [15:0] req_base_addr, req_word_count;
  logic [5:0]  req_mode;
  logic [7:0]  stat_data, db_out, db_in;
  logic        cs_n, ior_n, iow_n, db_oe;
  logic [3:0]  a;

  logic        req_valid3, req_ready3, stat_valid3, done3, readback_err3;
  logic [7:0]  stat_data3, db_out3;
  logic        cs_n3, ior_n3, iow_n3, db_oe3;
  logic [3:0]  a3;

  dma_cpu_programmer #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_channel(req_channel),
    .req_base_addr(req_base_addr), .req_word_count(req_word_count), .req_mode(req_mode),
    .req_unmask(req_unmask), .stat_req(stat_req), .stat_valid(stat_valid),
    .stat_data(stat_data), .done(done), .readback_err(readback_err),
    .CS_N(cs_n), .IOR_N(ior_n), .IOW_N(iow_n), .A(a), .DB_out(db_out), .DB_oe(db_oe),
    .DB_in(db_in)
  );

  dma_cpu_programmer #(.STROBE_CYCLES(3), .GAP_CYCLES(0)) dut3 (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_channel(req_channel),
    .req_base_addr(req_base_addr), .req_word_count(req_word_count), .req_mode(req_mode),
    .req_unmask(req_unmask), .stat_req(1'b0), .stat_valid(stat_valid3),
    .stat_data(stat_data3), .done(done3), .readback_err(readback_err3),
    .CS_N(cs_n3), .IOR_N(ior_n3), .IOW_N(iow_n3), .A(a3), .DB_out(db_out3), .DB_oe(db_oe3),
    .DB_in(db_in)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural DMA slave: byte-pointer flip-flop plus per-channel address/count words.
  logic [15:0] m_addr [4];
  logic [15:0] m_cnt  [4];
  logic [15:0] m_word;
  logic        bpff = 1'b0;
  logic        corrupt = 1'b0;
  logic [7:0]  stat_byte = 8'h00;

  always @(posedge iow_n) begin
    if (cs_n === 1'b0) begin
      if (a == 4'd12) bpff <= 1'b0;
      else if (a < 4'd8) begin
        if (a[0]) begin
          if (bpff) m_cnt[a[2:1]][15:8] <= db_out; else m_cnt[a[2:1]][7:0] <= db_out;
        end else begin
          if (bpff) m_addr[a[2:1]][15:8] <= db_out; else m_addr[a[2:1]][7:0] <= db_out;
        end
        bpff <= ~bpff;
      end
    end
  end

  always @(posedge ior_n) if (cs_n === 1'b0 && a < 4'd8) bpff <= ~bpff;

  always_comb begin
    m_word = a[0] ? m_cnt[a[2:1]] : m_addr[a[2:1]];
    db_in  = stat_byte;
    if (a < 4'd8) begin
      db_in = bpff ? m_word[15:8] : m_word[7:0];
      if (corrupt && !a[0] && bpff) db_in = 8'h13;
    end
  end

  // Bus monitors: one record per strobe, sampled on the falling clock edge.
  acc_t cur;
  int   cur_w = 0;
  logic in_strb = 1'b0;
  acc_t mon_q[$];
  int   mon_w[$];
  int   both_low = 0, cs_bad = 0, oe_bad = 0, done_cnt = 0, stat_cnt = 0;

  always @(negedge CLK) begin
    if (done === 1'b1)       done_cnt <= done_cnt + 1;
    if (stat_valid === 1'b1) stat_cnt <= stat_cnt + 1;
    if (ior_n === 1'b0 || iow_n === 1'b0) begin
      if (!in_strb) begin
        in_strb <= 1'b1;
        cur_w   <= 1;
        cur     <= {~ior_n, a, (db_oe ? db_out : 8'h00)};
      end else begin
        cur_w <= cur_w + 1;
      end
      if (ior_n === 1'b0 && iow_n === 1'b0) both_low <= both_low + 1;
      if (cs_n !== 1'b0) cs_bad <= cs_bad + 1;
      if (db_oe !== ~iow_n) oe_bad <= oe_bad + 1;
    end else if (in_strb) begin
      in_strb <= 1'b0;
      mon_q.push_back(cur);
      mon_w.push_back(cur_w);
    end
  end

  int   w3 = 0;
  logic in3 = 1'b0;
  int   w3_q[$];
  int   both3 = 0;

  always @(negedge CLK) begin
    if (ior_n3 === 1'b0 || iow_n3 === 1'b0) begin
      if (!in3) begin in3 <= 1'b1; w3 <= 1; end
      else w3 <= w3 + 1;
      if (ior_n3 === 1'b0 && iow_n3 === 1'b0) both3 <= both3 + 1;
    end else if (in3) begin
      in3 <= 1'b0;
      w3_q.push_back(w3);
    end
  end

  // Reference access list for one setup request, straight from the register map.
  acc_t exp_q[$];

  task automatic build_exp(input logic [1:0] ch, input logic [15:0] ad, input logic [15:0] cn,
                           input logic [5:0] md, input logic um);
    logic [3:0] ra, rc;
    ra = 4'(2 * int'(ch));
    rc = 4'(2 * int'(ch) + 1);
    exp_q.delete();
    exp_q.push_back({1'b0, 4'd12, 8'h00});
    exp_q.push_back({1'b0, ra, ad[7:0]});
    exp_q.push_back({1'b0, ra, ad[15:8]});
    exp_q.push_back({1'b0, rc, cn[7:0]});
    exp_q.push_back({1'b0, rc, cn[15:8]});
    exp_q.push_back({1'b0, 4'd11, md, ch});
    if (um) exp_q.push_back({1'b0, 4'd10, 6'd0, ch});
`ifdef DMA_PROG_READBACK_EN
    exp_q.push_back({1'b0, 4'd12, 8'h00});
    exp_q.push_back({1'b1, ra, 8'h00});
    exp_q.push_back({1'b1, ra, 8'h00});
    exp_q.push_back({1'b1, rc, 8'h00});
    exp_q.push_back({1'b1, rc, 8'h00});
`endif
  endtask

  task automatic run_req(input logic [1:0] ch, input logic [15:0] ad, input logic [15:0] cn,
                         input logic [5:0] md, input logic um, input bit both,
                         input bit busy_stat, input string tag);
    int b0, d0, s0, cyc, rdy_bad, n;
    build_exp(ch, ad, cn, md, um);
    n = exp_q.size();
    @(negedge CLK);
    req_channel = ch; req_base_addr = ad; req_word_count = cn; req_mode = md; req_unmask = um;
    req_valid = 1'b1; stat_req = both;
    b0 = mon_q.size(); d0 = done_cnt; s0 = stat_cnt;
    check({tag, " ready_idle"}, req_ready, 1);
    @(posedge CLK); #1;
    req_valid = 1'b0; stat_req = 1'b0;
    cyc = 0; rdy_bad = 0;
    while (done !== 1'b1 && cyc < 500) begin
      if (req_ready !== 1'b0) rdy_bad++;
      if (busy_stat) stat_req = (cyc == 5);
      @(posedge CLK); #1;
      cyc++;
    end
    stat_req = 1'b0;
    check({tag, " done_seen"}, done, 1);
    check({tag, " latency"}, cyc, n * (2 + S + G));
    check({tag, " ready_busy"}, rdy_bad, 0);
    @(posedge CLK); #1;
    check({tag, " done_pulse"}, done, 0);
    check({tag, " ready_after"}, req_ready, 1);
    repeat (6) @(posedge CLK);
    check({tag, " access_count"}, mon_q.size() - b0, n);
    for (int i = 0; i < n && b0 + i < mon_q.size(); i++)
      check($sformatf("%s access%0d", tag, i), mon_q[b0 + i], exp_q[i]);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " stat_dropped"}, stat_cnt - s0, 0);
  endtask

  task automatic run_stat(input logic [7:0] val, input string tag);
    int b0, s0, cyc;
    @(negedge CLK);
    stat_byte = val; stat_req = 1'b1;
    b0 = mon_q.size(); s0 = stat_cnt;
    @(posedge CLK); #1;
    stat_req = 1'b0; cyc = 0;
    while (stat_valid !== 1'b1 && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, " valid"}, stat_valid, 1);
    check({tag, " data"}, stat_data, val);
    @(posedge CLK); #1;
    check({tag, " valid_pulse"}, stat_valid, 0);
    repeat (3) @(posedge CLK);
    check({tag, " access_count"}, mon_q.size() - b0, 1);
    if (mon_q.size() > b0) check({tag, " access"}, mon_q[b0], {1'b1, 4'd8, 8'h00});
    check({tag, " valid_count"}, stat_cnt - s0, 1);
  endtask

  task automatic run_req3(input logic um, input string tag);
    int b0, cyc, n, bad;
    build_exp(2'd3, 16'hBEEF, 16'h0102, 6'b101010, um);
    n = exp_q.size();
    @(negedge CLK);
    req_channel = 2'd3; req_base_addr = 16'hBEEF; req_word_count = 16'h0102;
    req_mode = 6'b101010; req_unmask = um; req_valid3 = 1'b1;
    b0 = w3_q.size();
    @(posedge CLK); #1;
    req_valid3 = 1'b0; cyc = 0;
    while (done3 !== 1'b1 && cyc < 500) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, n * 5);
    repeat (3) @(posedge CLK);
    check({tag, " access_count"}, w3_q.size() - b0, n);
    bad = 0;
    for (int i = b0; i < w3_q.size(); i++) if (w3_q[i] != 3) bad++;
    check({tag, " strobe_width"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, cyc, bad;
    req_valid = 1'b0; req_valid3 = 1'b0; stat_req = 1'b0; req_unmask = 1'b0;
    req_channel = 2'd0; req_base_addr = 16'h0; req_word_count = 16'h0; req_mode = 6'd0;
    RESET_N = 1'b1;
    #2 RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset cs_n", cs_n, 1);
    check("reset strobes", {ior_n, iow_n}, 2'b11);
    check("reset a", a, 0);
    check("reset db_out", db_out, 0);
    check("reset db_oe", db_oe, 0);
    check("reset ready", req_ready, 1);
    check("reset done_stat", {done, stat_valid}, 2'b00);
    check("reset stat_data", stat_data, 0);
    check("reset readback_err", readback_err, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    run_req(2'd2, 16'h1234, 16'h00FF, 6'b010001, 1'b1, 1'b0, 1'b0, "spec_unmask");
    run_req(2'd2, 16'h1234, 16'h00FF, 6'b010001, 1'b0, 1'b1, 1'b0, "spec_nounmask");
    run_stat(8'hA5, "stat_a5");
    run_stat(8'($urandom), "stat_rand");
    run_req(2'd3, 16'hFEDC, 16'h8001, 6'b111111, 1'b1, 1'b0, 1'b1, "ch3_wrap");
    for (int k = 0; k < 5; k++)
      run_req(2'($urandom), 16'($urandom), 16'($urandom), 6'($urandom), 1'($urandom),
              1'b0, k[0], $sformatf("rand%0d", k));
    check("readback_err clean", readback_err, 0);

`ifdef DMA_PROG_READBACK_EN
    corrupt = 1'b1;
    run_req(2'd1, 16'h1234, 16'h5678, 6'b000100, 1'b0, 1'b0, 1'b0, "rb_corrupt");
    check("readback_err set", readback_err, 1);
    corrupt = 1'b0;
    run_req(2'd1, 16'h1234, 16'h5678, 6'b000100, 1'b0, 1'b0, 1'b0, "rb_clean");
    check("readback_err sticky", readback_err, 1);
`endif

    // Abort during the ADDR_HI strobe (third access).
    @(negedge CLK);
    req_channel = 2'd1; req_base_addr = 16'hAB12; req_word_count = 16'h0033;
    req_mode = 6'd5; req_unmask = 1'b1; req_valid = 1'b1;
    b0 = mon_q.size();
    @(posedge CLK); #1;
    req_valid = 1'b0; cyc = 0;
    while (!(mon_q.size() >= b0 + 2 && iow_n === 1'b0) && cyc < 200) begin
      @(negedge CLK); #1;
      cyc++;
    end
    check("abort in_strobe", iow_n, 0);
    check("abort addr_hi_reg", a, 4'd2);
    #2 RESET_N = 1'b0;
    #1;
    check("abort cs_n", cs_n, 1);
    check("abort iow_n", iow_n, 1);
    check("abort db_oe", db_oe, 0);
    check("abort ready", req_ready, 1);
    check("abort readback_err", readback_err, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    run_req(2'd1, 16'hAB12, 16'h0033, 6'd5, 1'b1, 1'b0, 1'b0, "after_abort");

    run_req3(1'b1, "s3g0_unmask");
    run_req3(1'b0, "s3g0_nounmask");
    check("s3g0 both_low", both3, 0);

    bad = 0;
    foreach (mon_w[i]) if (mon_w[i] != S) bad++;
    check("strobe_width", bad, 0);
    check("both_low", both_low, 0);
    check("cs_during_strobe", cs_bad, 0);
    check("oe_matches_write", oe_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
